// File: rtl/vmem_port_arbiter.sv
// Port-B arbiter for the vector data memory: shares one 128-bit RAM port between the
// vector pipeline memory stage and the audio sample DMA engine, one access per cycle.
module vmem_port_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 128,
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    // CPU (vector memory stage)
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [DW-1:0]    cpu_rdata,
    // DMA engine
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [AW-1:0]    dma_addr,
    input  logic [LEN_W-1:0] dma_len,
    input  logic [DW-1:0]    dma_wdata,
    output logic             dma_beat,
    output logic             dma_rvalid,
    output logic [DW-1:0]    dma_rdata,
    output logic             dma_done,
    output logic             busy,
    // RAM port B
    output logic [AW-1:0]    address_b,
    output logic [DW-1:0]    data_b,
    output logic             wren_b,
    input  logic [DW-1:0]    q_b
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StArb, StBurst} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [AW-1:0]    baddr_q, baddr_d;
    logic             bwe_q, bwe_d;
    logic             rv_q, rown_q;
    logic [AW-1:0]    addr_last_q;
    logic [DW-1:0]    data_last_q;
    logic             starved;

    assign starved = (starve_q == SW'(STARVE_LIMIT));

    // State register and control counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StArb;
            starve_q <= '0;
            rem_q    <= '0;
            baddr_q  <= '0;
            bwe_q    <= 1'b0;
            rv_q     <= 1'b0;
            rown_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rem_q    <= rem_d;
            baddr_q  <= baddr_d;
            bwe_q    <= bwe_d;
            // Read-return pipe: one entry per granted read, owner 1 = DMA
            rv_q     <= (cpu_gnt & ~cpu_we) | (dma_beat & ~wren_b);
            rown_q   <= dma_beat;
        end
    end

    // Last driven RAM address/data, held while nobody is granted
    always_ff @(posedge clk) begin
        if (cpu_gnt || dma_beat) begin
            addr_last_q <= address_b;
            data_last_q <= data_b;
        end
    end

    // Next-state: burst sequencing and DMA starvation counter
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        rem_d    = rem_q;
        baddr_d  = baddr_q;
        bwe_d    = bwe_q;
        unique case (state_q)
            StArb: begin
                if (dma_beat) begin
                    starve_d = '0;
                    baddr_d  = dma_addr + AW'(1);
                    bwe_d    = dma_we;
                    rem_d    = dma_len;
                    if (dma_len != '0) state_d = StBurst;
                end else if (dma_req) begin
                    starve_d = starved ? starve_q : starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                end
            end
            StBurst: begin
                baddr_d = baddr_q + AW'(1);
                rem_d   = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    // Outputs: grant decision and RAM port steering
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_beat  = 1'b0;
        dma_done  = 1'b0;
        address_b = addr_last_q;
        data_b    = data_last_q;
        wren_b    = 1'b0;
        unique case (state_q)
            StArb: begin
                if (dma_req && starved) begin
                    dma_beat = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dma_req) begin
                    dma_beat = 1'b1;
                end
                if (dma_beat) begin
                    address_b = dma_addr;
                    data_b    = dma_wdata;
                    wren_b    = dma_we;
                    dma_done  = (dma_len == '0);
                end else if (cpu_gnt) begin
                    address_b = cpu_addr;
                    data_b    = cpu_wdata;
                    wren_b    = cpu_we;
                end
            end
            StBurst: begin
                dma_beat  = 1'b1;
                address_b = baddr_q;
                data_b    = dma_wdata;
                wren_b    = bwe_q;
                dma_done  = (rem_q == LEN_W'(1));
            end
            default: ;
        endcase
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign busy       = (state_q == StBurst);
    assign cpu_rvalid = rv_q & ~rown_q;
    assign dma_rvalid = rv_q & rown_q;
    assign cpu_rdata  = q_b;
    assign dma_rdata  = q_b;

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Directed bench for vmem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vmem_port_arbiter;

    logic         clk;
    logic         reset;
    logic         cpu_req, cpu_we;
    logic [7:0]   cpu_addr;
    logic [127:0] cpu_wdata;
    logic         cpu_gnt, cpu_stall, cpu_rvalid;
    logic [127:0] cpu_rdata;
    logic         dma_req, dma_we;
    logic [7:0]   dma_addr;
    logic [3:0]   dma_len;
    logic [127:0] dma_wdata;
    logic         dma_beat, dma_rvalid, dma_done, busy;
    logic [127:0] dma_rdata;
    logic [7:0]   address_b;
    logic [127:0] data_b;
    logic         wren_b;
    logic [127:0] q_b;

    int errors = 0;
    int checks = 0;

    logic [127:0] mem [256];

    vmem_port_arbiter #(
        .AW(8), .DW(128), .LEN_W(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_beat(dma_beat), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .dma_done(dma_done), .busy(busy),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read (1-cycle latency)
    always @(posedge clk) begin
        if (wren_b) mem[address_b] <= data_b;
        q_b <= mem[address_b];
    end

    function automatic logic [127:0] pat(input logic [7:0] a);
        return {8{a, a ^ 8'h3C}};
    endfunction

    function automatic logic [127:0] wpat(input int i);
        return {4{32'hD00D0000 + i}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
    endtask

    typedef struct {
        logic         cpu_req, cpu_we;
        logic [7:0]   cpu_addr;
        logic [127:0] cpu_wdata;
        logic         dma_req, dma_we;
        logic [7:0]   dma_addr;
        logic [3:0]   dma_len;
        logic [127:0] dma_wdata;
        logic         e_cgnt, e_stall, e_beat, e_wren, e_done, e_crv, e_drv;
        logic [7:0]   e_addr;
        logic [127:0] e_data;
        logic [127:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [7:0] ca, input logic [127:0] cd,
        input logic dr, input logic dw, input logic [7:0] da, input logic [3:0] dl,
        input logic [127:0] dd,
        input logic eg, input logic es, input logic eb, input logic ew, input logic edn,
        input logic ecr, input logic edr, input logic [7:0] ea, input logic [127:0] ed,
        input logic [127:0] er);
        vec_t v;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
        v.dma_req = dr; v.dma_we = dw; v.dma_addr = da; v.dma_len = dl; v.dma_wdata = dd;
        v.e_cgnt = eg; v.e_stall = es; v.e_beat = eb; v.e_wren = ew; v.e_done = edn;
        v.e_crv = ecr; v.e_drv = edr; v.e_addr = ea; v.e_data = ed; v.e_rdata = er;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w1, w2;
        for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
        w1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        w2 = 128'hCAFE_BABE_0123_4567_89AB_CDEF_FEED_F00D;

        //             cpu: req we addr  wdata   dma: req we addr len wdata
        //             exp: gnt stall beat wren done crv drv addr data rdata
        vecs[0] = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        vecs[1] = mk(1, 0, 8'h10, 0,  0, 0, 8'h00, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 8'h10, 0, 0);
        vecs[2] = mk(1, 1, 8'h11, w1, 0, 0, 8'h00, 0, 0,
                     1, 0, 0, 1, 0, 1, 0, 8'h11, w1, pat(8'h10));
        vecs[3] = mk(1, 0, 8'h12, 0,  1, 0, 8'h30, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 8'h12, 0, 0);
        vecs[4] = mk(0, 0, 8'h00, 0,  1, 0, 8'h30, 0, 0,
                     0, 0, 1, 0, 1, 1, 0, 8'h30, 0, pat(8'h12));
        vecs[5] = mk(1, 0, 8'h13, 0,  1, 1, 8'h40, 0, w2,
                     1, 0, 0, 0, 0, 0, 1, 8'h13, 0, pat(8'h30));
        vecs[6] = mk(0, 0, 8'h00, 0,  1, 1, 8'h40, 0, w2,
                     0, 0, 1, 1, 1, 1, 0, 8'h40, w2, pat(8'h13));
        vecs[7] = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

        // Reset
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst cpu_rvalid", cpu_rvalid, 0);
        chk("rst dma_rvalid", dma_rvalid, 0);
        chk("rst dma_done", dma_done, 0);
        chk("rst wren_b", wren_b, 0);
        chk("rst cpu_gnt", cpu_gnt, 0);
        tick();

        // Table-driven single-cycle arbitration vectors
        for (int i = 0; i < 8; i++) begin
            cpu_req = vecs[i].cpu_req; cpu_we = vecs[i].cpu_we;
            cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata;
            dma_req = vecs[i].dma_req; dma_we = vecs[i].dma_we;
            dma_addr = vecs[i].dma_addr; dma_len = vecs[i].dma_len;
            dma_wdata = vecs[i].dma_wdata;
            @(negedge clk);
            chk($sformatf("vec%0d cpu_gnt", i), cpu_gnt, vecs[i].e_cgnt);
            chk($sformatf("vec%0d cpu_stall", i), cpu_stall, vecs[i].e_stall);
            chk($sformatf("vec%0d dma_beat", i), dma_beat, vecs[i].e_beat);
            chk($sformatf("vec%0d wren_b", i), wren_b, vecs[i].e_wren);
            chk($sformatf("vec%0d dma_done", i), dma_done, vecs[i].e_done);
            chk($sformatf("vec%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
            chk($sformatf("vec%0d dma_rvalid", i), dma_rvalid, vecs[i].e_drv);
            chk($sformatf("vec%0d busy", i), busy, 0);
            if (vecs[i].e_cgnt || vecs[i].e_beat)
                chk($sformatf("vec%0d address_b", i), address_b, vecs[i].e_addr);
            if (vecs[i].e_wren)
                chk($sformatf("vec%0d data_b", i), data_b, vecs[i].e_data);
            if (vecs[i].e_crv)
                chk($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].e_drv)
                chk($sformatf("vec%0d dma_rdata", i), dma_rdata, vecs[i].e_rdata);
            tick();
        end
        idle_inputs();
        tick();

        // DMA write burst, len=3 at 0x20
        dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_len = 3; dma_wdata = wpat(0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk($sformatf("wburst b%0d dma_beat", b), dma_beat, 1);
            chk($sformatf("wburst b%0d address_b", b), address_b, 8'h20 + 8'(b));
            chk($sformatf("wburst b%0d wren_b", b), wren_b, 1);
            chk($sformatf("wburst b%0d data_b", b), data_b, wpat(b));
            chk($sformatf("wburst b%0d busy", b), busy, b != 0);
            chk($sformatf("wburst b%0d dma_done", b), dma_done, b == 3);
            tick();
            dma_req = 0;
            dma_wdata = wpat(b + 1);
        end
        idle_inputs();
        @(negedge clk);
        chk("wburst end busy", busy, 0);
        chk("wburst end dma_beat", dma_beat, 0);
        tick();
        cpu_req = 1; cpu_addr = 8'h22;
        tick();
        cpu_req = 0;
        @(negedge clk);
        chk("wburst readback rvalid", cpu_rvalid, 1);
        chk("wburst readback data", cpu_rdata, wpat(2));
        tick();

        // CPU request during a len=3 read burst at 0x50
        dma_req = 1; dma_we = 0; dma_addr = 8'h50; dma_len = 3;
        @(negedge clk);
        chk("cdb b0 dma_beat", dma_beat, 1);
        tick();
        dma_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h60;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("cdb c%0d cpu_stall", c), cpu_stall, 1);
            chk($sformatf("cdb c%0d cpu_gnt", c), cpu_gnt, 0);
            chk($sformatf("cdb c%0d dma_done", c), dma_done, c == 3);
            chk($sformatf("cdb c%0d dma_rvalid", c), dma_rvalid, 1);
            chk($sformatf("cdb c%0d dma_rdata", c), dma_rdata, pat(8'h50 + 8'(c - 1)));
            tick();
        end
        @(negedge clk);
        chk("cdb after cpu_gnt", cpu_gnt, 1);
        chk("cdb after cpu_stall", cpu_stall, 0);
        chk("cdb after address_b", address_b, 8'h60);
        chk("cdb after dma_rdata", dma_rdata, pat(8'h53));
        tick();
        cpu_req = 0;
        @(negedge clk);
        chk("cdb cpu_rvalid", cpu_rvalid, 1);
        chk("cdb cpu_rdata", cpu_rdata, pat(8'h60));
        tick();

        // Starvation: CPU holds the port, DMA forced in on the 9th cycle
        cpu_req = 1; cpu_addr = 8'h70;
        dma_req = 1; dma_we = 0; dma_addr = 8'h80; dma_len = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("starve k%0d cpu_gnt", k), cpu_gnt, 1);
            chk($sformatf("starve k%0d dma_beat", k), dma_beat, 0);
            tick();
        end
        @(negedge clk);
        chk("starve k9 cpu_gnt", cpu_gnt, 0);
        chk("starve k9 cpu_stall", cpu_stall, 1);
        chk("starve k9 dma_beat", dma_beat, 1);
        chk("starve k9 dma_done", dma_done, 1);
        chk("starve k9 address_b", address_b, 8'h80);
        tick();
        @(negedge clk);
        chk("starve k10 cpu_gnt", cpu_gnt, 1);
        chk("starve k10 dma_beat", dma_beat, 0);
        chk("starve k10 dma_rvalid", dma_rvalid, 1);
        chk("starve k10 dma_rdata", dma_rdata, pat(8'h80));
        tick();
        idle_inputs();
        tick();

        // Address wrap on a len=2 read burst at 0xFE
        dma_req = 1; dma_we = 0; dma_addr = 8'hFE; dma_len = 2;
        @(negedge clk);
        chk("wrap b0 address_b", address_b, 8'hFE);
        chk("wrap b0 dma_beat", dma_beat, 1);
        tick();
        dma_req = 0;
        @(negedge clk);
        chk("wrap b1 address_b", address_b, 8'hFF);
        chk("wrap b1 busy", busy, 1);
        chk("wrap b1 dma_rdata", dma_rdata, pat(8'hFE));
        tick();
        @(negedge clk);
        chk("wrap b2 address_b", address_b, 8'h00);
        chk("wrap b2 dma_done", dma_done, 1);
        chk("wrap b2 dma_rvalid", dma_rvalid, 1);
        chk("wrap b2 dma_rdata", dma_rdata, pat(8'hFF));
        tick();
        @(negedge clk);
        chk("wrap b3 dma_rvalid", dma_rvalid, 1);
        chk("wrap b3 dma_rdata", dma_rdata, pat(8'h00));
        chk("wrap b3 busy", busy, 0);
        chk("wrap b3 wren_b", wren_b, 0);
        tick();

        // Reset on the 2nd beat of a len=5 read burst
        dma_req = 1; dma_we = 0; dma_addr = 8'h90; dma_len = 5;
        @(negedge clk);
        chk("rmb b0 dma_beat", dma_beat, 1);
        tick();
        dma_req = 0;
        reset = 1;
        @(negedge clk);
        chk("rmb b1 busy", busy, 1);
        chk("rmb b1 address_b", address_b, 8'h91);
        tick();
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'hA0;
        @(negedge clk);
        chk("rmb busy", busy, 0);
        chk("rmb dma_rvalid", dma_rvalid, 0);
        chk("rmb dma_done", dma_done, 0);
        chk("rmb cpu_gnt", cpu_gnt, 1);
        chk("rmb dma_beat", dma_beat, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("rmb cpu_rvalid", cpu_rvalid, 1);
        chk("rmb cpu_rdata", cpu_rdata, pat(8'hA0));
        chk("rmb late dma_rvalid", dma_rvalid, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
